bias_loader: RTL and testbench
==============================

// Module: bias_loader
// PURPOSE
//  Write side of the LSTM bias store. Takes a gate-major stream of bias words
//  from the host over a valid/ready handshake and writes them to the per-gate
//  bias memory read by the bias-add stage. Order: gate 0 (i), 1 (f), 2 (o), 3 (g);
//  units 0..UNIT-1 within each gate. One load is GATES*UNIT words.
// PARAMETERS
//  DWIDTH  16               bias word width (Q-format fixed point, passed through)
//  UNIT    32               hidden units per gate
//  GATES   4                number of gates
//  UWIDTH  $clog2(UNIT)     unit-address width
//  GWIDTH  $clog2(GATES)    gate-select width
// PORTS
//  clk        in   1       clock, rising edge
//  xrst       in   1       reset, asynchronous, active-low
//  start      in   1       begin a load; sampled only in IDLE
//  abort      in   1       synchronous cancel of a load in progress
//  s_valid    in   1       host word valid
//  s_ready    out  1       loader ready for a host word
//  s_data     in   DWIDTH  host bias word
//  mem_we     out  1       bias memory write enable
//  mem_gate   out  GWIDTH  gate select of write
//  mem_addr   out  UWIDTH  unit address of write
//  mem_wdata  out  DWIDTH  write data
//  busy       out  1       high in LOAD state
//  done       out  1       one-cycle pulse on the last write
//  exp_sum    in   32      expected checksum (BIAS_LOADER_CHECKSUM_EN only)
//  sum_err    out  1       checksum mismatch (BIAS_LOADER_CHECKSUM_EN only)
// BEHAVIOUR
//  - All outputs are registered. xrst low: state=IDLE, counters=0, all outputs 0.
//  - FSM IDLE -> LOAD on start. LOAD -> IDLE on the last accepted word or on abort.
//  - IDLE: s_ready=0, busy=0. start clears the gate and unit counters; s_ready=1
//    and busy=1 from the next cycle.
//  - LOAD: a word is accepted when s_valid & s_ready. One cycle later: mem_we=1,
//    mem_gate/mem_addr = counters at acceptance, mem_wdata = s_data.
//    mem_we=0 in every cycle that follows no acceptance.
//  - Counters: the unit counter increments per accepted word. At UNIT-1 it wraps
//    to 0 and the gate counter increments.
//  - Last word (gate=GATES-1, unit=UNIT-1) accepted: s_ready=0 and busy=0 next
//    cycle; done=1 in the same cycle as that word's mem_we. Then IDLE.
//  - start while in LOAD is ignored. start in the cycle done pulses starts a
//    new load (FSM is in IDLE then).
//  - abort in LOAD: IDLE next cycle, no done, counters cleared.
//    abort has priority over a same-cycle handshake: that word is not written.
//    Words already written stay in memory. abort in IDLE has no effect.
//  - xrst asserted mid-load: immediate return to IDLE, partial load discarded,
//    no done pulse.
//  - s_valid high without s_ready has no effect. Data is passed without arithmetic.
//  - Throughput: 1 word/cycle. Full load = GATES*UNIT accept cycles + 1.
// CONFIGURATION
//  BIAS_LOADER_CHECKSUM_EN defined:
//   - A 32-bit running sum of zero-extended s_data over accepted words; it
//     wraps modulo 2^32 and clears on start.
//   - At done, sum_err <= (sum != exp_sum). sum_err holds until the next start
//     or xrst. abort leaves sum_err unchanged.
//  Not defined:
//   - No exp_sum/sum_err ports, no checksum logic.
// TESTING  (bench builds UNIT=4, GATES=4, DWIDTH=16; 16 words per load)
//  1. Reset: xrst=0 with s_valid=1 and start=1 -> all outputs 0; s_ready stays 0
//     until a start after release.
//  2. Full load: start, s_valid held high, data 0x0100..0x010F ->
//     mem_we on 16 consecutive cycles; gate/addr (0,0)..(3,3); data matches;
//     done in the 16th write cycle; busy low after.
//  3. Backpressure gaps: s_valid toggles 1,0,0,1 -> writes only for accepted
//     words, addr sequence unbroken, unit wraps 3->0 with gate 0->1.
//  4. Abort at word 6 with s_valid=1 -> words 0..5 written, word 6 not written,
//     no done, s_ready=0 next cycle; a new start writes from (0,0).
//  5. start pulsed mid-load at word 3 -> ignored, counters continue.
//     xrst pulsed at word 9 -> outputs 0, no done.
//  6. CHECKSUM_EN: data all 0xFFFF, exp_sum=0x000FFFF0 -> sum_err=0.
//     Same run with exp_sum=0 -> sum_err=1 at done; it clears on the next start.

Source files
------------

// File: rtl/bias_loader.sv
// Purpose : LSTM bias store write side. It takes a gate-major stream of bias words over
//           valid/ready and writes each one to the per-gate bias memory.
// Latency : a word accepted in cycle N is written (mem_we) in cycle N+1. A full load takes
//           GATES*UNIT accept cycles + 1.
// Backpr. : s_ready is high for the whole LOAD state, so at most 1 word/cycle is taken.
//           s_valid gaps insert idle cycles and do not disturb the address sequence.
//
// Optional feature macro: BIAS_LOADER_CHECKSUM_EN
//   Adds the exp_sum input and the sum_err output. It keeps a 32-bit running sum of the
//   accepted words and compares it with exp_sum when the load completes.
//
// Ports
//   clk, xrst            clock (rising edge), asynchronous active-low reset
//   start / abort        begin a load (taken in IDLE) / cancel a load (taken in LOAD)
//   s_valid/s_ready/s_data   host word handshake
//   mem_we/mem_gate/mem_addr/mem_wdata   bias memory write port (registered)
//   busy / done          high in LOAD / one-cycle pulse with the last write
//   exp_sum / sum_err    expected checksum in, mismatch flag out (checksum build only)
module bias_loader #(
  parameter int DWIDTH = 16,
  parameter int UNIT   = 32,
  parameter int GATES  = 4,
  parameter int UWIDTH = $clog2(UNIT),
  parameter int GWIDTH = $clog2(GATES)
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              mem_we,
  output logic [GWIDTH-1:0] mem_gate,
  output logic [UWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              busy,
  output logic              done
`ifdef BIAS_LOADER_CHECKSUM_EN
  ,
  input  logic [31:0]       exp_sum,
  output logic              sum_err
`endif
);

  localparam logic [UWIDTH-1:0] LAST_UNIT = UWIDTH'(UNIT - 1);
  localparam logic [GWIDTH-1:0] LAST_GATE = GWIDTH'(GATES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [GWIDTH-1:0] gate_q, gate_d;
  logic [UWIDTH-1:0] unit_q, unit_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic [GWIDTH-1:0] mem_gate_q, mem_gate_d;
  logic [UWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;

  // s_ready_q is only ever high in LOAD, so it qualifies the handshake on its own.
  logic accept;
  logic last_word;
  assign accept    = s_valid & s_ready_q;
  assign last_word = (gate_q == LAST_GATE) && (unit_q == LAST_UNIT);

`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        sum_err_q, sum_err_d;
  logic [31:0] sum_acc;
  // The sum includes the word being accepted, so the last word is covered at done.
  assign sum_acc = sum_q + 32'(s_data);
`endif

  // State register
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. abort is checked before the handshake, so it wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept && last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and counter next values
  always_comb begin
    gate_d      = gate_q;
    unit_d      = unit_q;
    s_ready_d   = s_ready_q;
    busy_d      = busy_q;
    mem_we_d    = 1'b0;
    mem_gate_d  = mem_gate_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    sum_err_d   = sum_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          gate_d    = '0;
          unit_d    = '0;
          s_ready_d = 1'b1;
          busy_d    = 1'b1;
`ifdef BIAS_LOADER_CHECKSUM_EN
          sum_d     = '0;
          sum_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (abort) begin
          // Words already written stay in memory. Only the sequencing is dropped.
          gate_d    = '0;
          unit_d    = '0;
          s_ready_d = 1'b0;
          busy_d    = 1'b0;
        end else if (accept) begin
          mem_we_d    = 1'b1;
          mem_gate_d  = gate_q;
          mem_addr_d  = unit_q;
          mem_wdata_d = s_data;
`ifdef BIAS_LOADER_CHECKSUM_EN
          sum_d       = sum_acc;
`endif
          if (last_word) begin
            done_d    = 1'b1;
            s_ready_d = 1'b0;
            busy_d    = 1'b0;
            gate_d    = '0;
            unit_d    = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_err_d = (sum_acc != exp_sum);
`endif
          end else if (unit_q == LAST_UNIT) begin
            unit_d = '0;
            gate_d = gate_q + GWIDTH'(1);
          end else begin
            unit_d = unit_q + UWIDTH'(1);
          end
        end
      end
      default: begin
        s_ready_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      gate_q      <= '0;
      unit_q      <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_gate_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      sum_err_q   <= 1'b0;
`endif
    end else begin
      gate_q      <= gate_d;
      unit_q      <= unit_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_gate_q  <= mem_gate_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
`ifdef BIAS_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      sum_err_q   <= sum_err_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign mem_we    = mem_we_q;
  assign mem_gate  = mem_gate_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
`ifdef BIAS_LOADER_CHECKSUM_EN
  assign sum_err   = sum_err_q;
`endif

endmodule

// File: tb/tb_bias_loader.sv
module tb_bias_loader;
  localparam int DW = 16;
  localparam int UN = 4;
  localparam int GA = 4;
  localparam int UW = 2;
  localparam int GW = 2;
  localparam int NW = GA * UN;

  logic          clk = 1'b0;
  logic          xrst, start, abort, s_valid, s_ready;
  logic [DW-1:0] s_data, mem_wdata;
  logic          mem_we, busy, done;
  logic [GW-1:0] mem_gate;
  logic [UW-1:0] mem_addr;
`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [31:0]   exp_sum;
  logic          sum_err;
`endif

  always #5 clk = ~clk;

  bias_loader #(.DWIDTH(DW), .UNIT(UN), .GATES(GA)) dut (
    .clk(clk), .xrst(xrst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_gate(mem_gate), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
`ifdef BIAS_LOADER_CHECKSUM_EN
    , .exp_sum(exp_sum), .sum_err(sum_err)
`endif
  );

  typedef struct {
    logic [GW-1:0] gate;
    logic [UW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  wr_seen = 0;
  int  done_seen = 0;

  // Bench-side model of the load sequencer: drives what the scoreboard expects.
  bit  m_load = 1'b0;
  int  m_gate = 0;
  int  m_unit = 0;

  // Scoreboard: every write is popped and compared against the expected entry.
  always @(negedge clk) begin
    if (xrst === 1'b1 && mem_we === 1'b1) begin
      wr_seen++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write got g=%0d a=%0d d=%h, no write expected",
                 mem_gate, mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_gate !== mon_e.gate || mem_addr !== mon_e.addr ||
            mem_wdata !== mon_e.data || done !== mon_e.last)
          $display("FAIL write_check got g=%0d a=%0d d=%h done=%b expected g=%0d a=%0d d=%h done=%b",
                   mem_gate, mem_addr, mem_wdata, done,
                   mon_e.gate, mon_e.addr, mon_e.data, mon_e.last);
        else
          pass_cnt++;
      end
    end
    if (xrst === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (mem_we !== 1'b1) begin
        total_cnt++;
        $display("FAIL done_without_write got mem_we=%b expected 1", mem_we);
      end
    end
  end

  // Drive one cycle of inputs. The call returns 1 time unit after the sampling edge.
  task automatic tick(input bit st, input bit vld, input logic [DW-1:0] d, input bit ab);
    wr_t e;
    start = st; s_valid = vld; s_data = d; abort = ab;
    if (!m_load) begin
      if (st) begin m_load = 1'b1; m_gate = 0; m_unit = 0; end
    end else if (ab) begin
      m_load = 1'b0; m_gate = 0; m_unit = 0;
    end else if (vld) begin
      e.gate = m_gate[GW-1:0];
      e.addr = m_unit[UW-1:0];
      e.data = d;
      e.last = (m_gate == GA - 1) && (m_unit == UN - 1);
      exp_q.push_back(e);
      if (e.last) m_load = 1'b0;
      if (m_unit == UN - 1) begin m_unit = 0; m_gate++; end else m_unit++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int w0;
    xrst = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = 16'hABCD; abort = 1'b0;
    m_load = 1'b0; exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({s_ready, busy} !== 2'b00) $display("FAIL reset_ready_busy got %b want 00", {s_ready, busy});
    else pass_cnt++;
    total_cnt++;
    if ({mem_we, done} !== 2'b00) $display("FAIL reset_we_done got %b want 00", {mem_we, done});
    else pass_cnt++;
    total_cnt++;
    if ({mem_gate, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_mem_outputs got g=%0d a=%0d d=%h want 0", mem_gate, mem_addr, mem_wdata);
    else pass_cnt++;
    start = 1'b0;
    xrst = 1'b1;
    w0 = wr_seen;
    repeat (3) tick(1'b0, 1'b1, 16'h5555, 1'b0);
    total_cnt++;
    if ({s_ready, busy} !== 2'b00 || wr_seen != w0)
      $display("FAIL reset_no_start got ready=%b busy=%b writes=%0d want 0 0 0",
               s_ready, busy, wr_seen - w0);
    else pass_cnt++;
  endtask

  task automatic test_full_load;
    int w0, d0;
    w0 = wr_seen; d0 = done_seen;
    tick(1'b1, 1'b0, '0, 1'b0);
    total_cnt++;
    if ({s_ready, busy} !== 2'b11) $display("FAIL full_start_ready got %b want 11", {s_ready, busy});
    else pass_cnt++;
    for (int i = 0; i < NW; i++) tick(1'b0, 1'b1, DW'(16'h0100 + i), 1'b0);
    total_cnt++;
    if ({mem_we, done, s_ready, busy} !== 4'b1100)
      $display("FAIL full_last_cycle got we/done/ready/busy=%b want 1100", {mem_we, done, s_ready, busy});
    else pass_cnt++;
    repeat (2) tick(1'b0, 1'b1, 16'hDEAD, 1'b0);
    total_cnt++;
    if (wr_seen - w0 != NW || done_seen - d0 != 1 || exp_q.size() != 0)
      $display("FAIL full_counts got writes=%0d dones=%0d pending=%0d want %0d 1 0",
               wr_seen - w0, done_seen - d0, exp_q.size(), NW);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int w0, d0, acc, idx;
    bit vld, gap_checked;
    w0 = wr_seen; d0 = done_seen; acc = 0; idx = 0; gap_checked = 1'b0;
    tick(1'b1, 1'b0, '0, 1'b0);
    while (acc < NW && idx < 200) begin
      vld = (idx % 4 == 0) || (idx % 4 == 3);
      tick(1'b0, vld, DW'(16'h0200 + acc), 1'b0);
      if (vld) acc++;
      else if (!gap_checked) begin
        gap_checked = 1'b1;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL gap_no_write got mem_we=%b want 0", mem_we);
        else pass_cnt++;
      end
      idx++;
    end
    repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
    total_cnt++;
    if (wr_seen - w0 != NW || done_seen - d0 != 1 || exp_q.size() != 0)
      $display("FAIL backpressure_counts got writes=%0d dones=%0d pending=%0d want %0d 1 0",
               wr_seen - w0, done_seen - d0, exp_q.size(), NW);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int w0, d0;
    w0 = wr_seen; d0 = done_seen;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, DW'(16'h0300 + i), 1'b0);
    tick(1'b0, 1'b1, 16'h0306, 1'b1);
    total_cnt++;
    if ({s_ready, busy, mem_we} !== 3'b000)
      $display("FAIL abort_next_cycle got ready/busy/we=%b want 000", {s_ready, busy, mem_we});
    else pass_cnt++;
    repeat (2) tick(1'b0, 1'b1, 16'h0307, 1'b0);
    total_cnt++;
    if (wr_seen - w0 != 6 || done_seen - d0 != 0 || exp_q.size() != 0)
      $display("FAIL abort_counts got writes=%0d dones=%0d pending=%0d want 6 0 0",
               wr_seen - w0, done_seen - d0, exp_q.size());
    else pass_cnt++;
    w0 = wr_seen; d0 = done_seen;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < NW; i++) tick(1'b0, 1'b1, DW'(16'h0310 + i), 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    total_cnt++;
    if (wr_seen - w0 != NW || done_seen - d0 != 1)
      $display("FAIL abort_reload got writes=%0d dones=%0d want %0d 1", wr_seen - w0, done_seen - d0, NW);
    else pass_cnt++;
  endtask

  task automatic test_start_and_reset_mid_load;
    int w0, d0;
    w0 = wr_seen; d0 = done_seen;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) tick(i == 3, 1'b1, DW'(16'h0400 + i), 1'b0);
    start = 1'b0; s_valid = 1'b0; abort = 1'b0;
    xrst = 1'b0;
    #1;
    total_cnt++;
    if ({s_ready, busy, mem_we, done} !== 4'b0000)
      $display("FAIL midload_reset got ready/busy/we/done=%b want 0000", {s_ready, busy, mem_we, done});
    else pass_cnt++;
    exp_q.delete(); m_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b1;
    repeat (2) tick(1'b0, 1'b1, 16'h0499, 1'b0);
    total_cnt++;
    if (wr_seen - w0 != 8 || done_seen - d0 != 0 || s_ready !== 1'b0)
      $display("FAIL midload_counts got writes=%0d dones=%0d ready=%b want 8 0 0",
               wr_seen - w0, done_seen - d0, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int w0, d0;
    w0 = wr_seen; d0 = done_seen;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < NW; i++) tick(1'b0, 1'b1, DW'(16'h0500 + i), 1'b0);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", done);
    else pass_cnt++;
    tick(1'b1, 1'b1, 16'h05FF, 1'b0);
    total_cnt++;
    if ({s_ready, busy} !== 2'b11) $display("FAIL b2b_restart got %b want 11", {s_ready, busy});
    else pass_cnt++;
    for (int i = 0; i < NW; i++) tick(1'b0, 1'b1, DW'(16'h0600 + i), 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    total_cnt++;
    if (wr_seen - w0 != 2 * NW || done_seen - d0 != 2 || exp_q.size() != 0)
      $display("FAIL b2b_counts got writes=%0d dones=%0d pending=%0d want %0d 2 0",
               wr_seen - w0, done_seen - d0, exp_q.size(), 2 * NW);
    else pass_cnt++;
  endtask

`ifdef BIAS_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    exp_sum = 32'h000F_FFF0;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < NW; i++) tick(1'b0, 1'b1, 16'hFFFF, 1'b0);
    total_cnt++;
    if ({done, sum_err} !== 2'b10) $display("FAIL sum_match got done/sum_err=%b want 10", {done, sum_err});
    else pass_cnt++;
    tick(1'b0, 1'b0, '0, 1'b0);
    exp_sum = 32'h0;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < NW; i++) tick(1'b0, 1'b1, 16'hFFFF, 1'b0);
    total_cnt++;
    if ({done, sum_err} !== 2'b11) $display("FAIL sum_mismatch got done/sum_err=%b want 11", {done, sum_err});
    else pass_cnt++;
    tick(1'b0, 1'b0, '0, 1'b0);
    total_cnt++;
    if (sum_err !== 1'b1) $display("FAIL sum_err_hold got %b want 1", sum_err);
    else pass_cnt++;
    tick(1'b1, 1'b0, '0, 1'b0);
    total_cnt++;
    if (sum_err !== 1'b0) $display("FAIL sum_err_clear got %b want 0", sum_err);
    else pass_cnt++;
    tick(1'b0, 1'b0, '0, 1'b1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout, simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    xrst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_start_and_reset_mid_load();
    test_back_to_back();
`ifdef BIAS_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
